// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix buffer loaders and the MAC array.
// State encoding, a width helper and the default element/packing geometry.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_ELEM_W = 7;
    localparam int DEFAULT_PACK   = 2;

    // Counter width for values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/matrix_word_packer.sv
// Assembles PACK elements into one word, first element in the MSBs, zero-filling on early flush.
// Word registered one cycle after its completing accept; never stalls its producer.
module matrix_word_packer
    import matrix_pkg::*;
#(
    parameter int ELEM_W = DEFAULT_ELEM_W,
    parameter int PACK   = DEFAULT_PACK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   accept,
    input  logic                   col_end,
    input  logic [ELEM_W-1:0]      elem,
    output logic                   word_complete,
    output logic                   word_valid,
    output logic [ELEM_W*PACK-1:0] word
);

    localparam int SLOT_W = clog2(PACK);
    localparam int WORD_W = ELEM_W * PACK;

    logic [SLOT_W-1:0] slot;
    logic [WORD_W-1:0] assembly;
    logic [WORD_W-1:0] merged;

    // Slots past the current one stay zero because assembly restarts from zero per word.
    always_comb begin
        merged = assembly;
        for (int k = 0; k < PACK; k++) begin
            if (slot == SLOT_W'(k)) begin
                merged[ELEM_W*(PACK-1-k) +: ELEM_W] = elem;
            end
        end
    end

    assign word_complete = accept && ((slot == SLOT_W'(PACK - 1)) || col_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot       <= '0;
            assembly   <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= word_complete;
            if (clear) begin
                slot     <= '0;
                assembly <= '0;
            end else if (word_complete) begin
                slot     <= '0;
                assembly <= '0;
                word     <= merged;
            end else if (accept) begin
                slot     <= slot + SLOT_W'(1);
                assembly <= merged;
            end
        end
    end

endmodule

// File: rtl/matrix_load_ctrl.sv
// Streams matrix elements into packed column-major words of the matrix buffer SRAM.
// One-cycle write latency; in_ready is high for the whole LOAD state, so stalls come only from in_valid.
module matrix_load_ctrl
    import matrix_pkg::*;
#(
    parameter int ELEM_W    = DEFAULT_ELEM_W,
    parameter int PACK      = DEFAULT_PACK,
    parameter int ROWS      = 8,
    parameter int COLS      = 4,
    parameter int ADDR_W    = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [ELEM_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [ELEM_W*PACK-1:0] mem_data,
    output logic                   busy,
    output logic                   done
);

    localparam int ROW_W = clog2(ROWS);
    localparam int COL_W = clog2(COLS);

    state_t            state;
    state_t            state_next;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] addr_cnt;
    logic              launch;
    logic              accept;
    logic              col_end;
    logic              last_elem;
    logic              word_complete;

    assign launch    = start && ((state == IDLE) || (state == DONE));
    assign accept    = in_valid && in_ready;
    assign col_end   = (row == ROW_W'(ROWS - 1));
    assign last_elem = accept && col_end && (col == COL_W'(COLS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (last_elem) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD);
        busy     = (state == LOAD) || (state == DRAIN);
        done     = (state == DONE);
    end

    // mem_addr is captured alongside the packed word so the pair appears together on the write cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            row      <= '0;
            col      <= '0;
            addr_cnt <= '0;
            mem_addr <= '0;
        end else if (launch) begin
            row      <= '0;
            col      <= '0;
            addr_cnt <= ADDR_W'(BASE_ADDR);
        end else begin
            if (accept) begin
                if (col_end) begin
                    row <= '0;
                    col <= col + COL_W'(1);
                end else begin
                    row <= row + ROW_W'(1);
                end
            end
            if (word_complete) begin
                mem_addr <= addr_cnt;
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end
        end
    end

    matrix_word_packer #(
        .ELEM_W (ELEM_W),
        .PACK   (PACK)
    ) u_packer (
        .clk           (clk),
        .rst           (rst),
        .clear         (launch),
        .accept        (accept),
        .col_end       (col_end),
        .elem          (in_data),
        .word_complete (word_complete),
        .word_valid    (mem_we),
        .word          (mem_data)
    );

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Bench for matrix_load_ctrl: four instances cover the default, offset-base, partial-word and unpacked geometries.
module tb_matrix_load_ctrl;

    typedef struct {
        int dut;
        int cyc;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int dut;
        int cyc;
    } acc_t;

    logic       clk;
    logic       rst;
    logic [3:0] start;
    logic       in_valid;
    logic [6:0] in_data;
    logic       rdy  [4];
    logic       we   [4];
    logic       busy [4];
    logic       done [4];
    logic [3:0]  a0, a2, a3;
    logic [4:0]  a1;
    logic [13:0] d0, d1, d2;
    logic [6:0]  d3;
    logic [31:0] maddr [4];
    logic [31:0] mdata [4];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   timed_out = 0;
    int   vals[$];
    int   exp_addr[$];
    int   exp_data[$];
    int   exp_idx[$];
    wr_t  wlog[$];
    acc_t alog[$];

    assign maddr[0] = 32'(a0);
    assign maddr[1] = 32'(a1);
    assign maddr[2] = 32'(a2);
    assign maddr[3] = 32'(a3);
    assign mdata[0] = 32'(d0);
    assign mdata[1] = 32'(d1);
    assign mdata[2] = 32'(d2);
    assign mdata[3] = 32'(d3);

    matrix_load_ctrl u_def (
        .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .mem_we(we[0]), .mem_addr(a0), .mem_data(d0), .busy(busy[0]), .done(done[0])
    );

    matrix_load_ctrl #(.ADDR_W(5), .BASE_ADDR(8)) u_base (
        .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .mem_we(we[1]), .mem_addr(a1), .mem_data(d1), .busy(busy[1]), .done(done[1])
    );

    matrix_load_ctrl #(.ROWS(5), .COLS(2), .PACK(2)) u_part (
        .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[2]), .mem_we(we[2]), .mem_addr(a2), .mem_data(d2), .busy(busy[2]), .done(done[2])
    );

    matrix_load_ctrl #(.ROWS(3), .COLS(1), .PACK(1)) u_p1 (
        .clk(clk), .rst(rst), .start(start[3]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[3]), .mem_we(we[3]), .mem_addr(a3), .mem_data(d3), .busy(busy[3]), .done(done[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every write and every accepted element with the cycle it happened in.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i] === 1'b1) wlog.push_back('{dut: i, cyc: cyc, addr: int'(maddr[i]), data: int'(mdata[i])});
            if (in_valid === 1'b1 && rdy[i] === 1'b1) alog.push_back('{dut: i, cyc: cyc});
        end
    end

    // Reference: column-major words, ceil(rows/pack) per column, first element in the MSBs, zero padding.
    task automatic build_model(input int rows, input int cols, input int pack, input int base);
        int a;
        int w;
        int last;
        exp_addr.delete(); exp_data.delete(); exp_idx.delete();
        a = base;
        for (int c = 0; c < cols; c++) begin
            for (int r0 = 0; r0 < rows; r0 += pack) begin
                w = 0;
                last = 0;
                for (int k = 0; k < pack; k++) begin
                    if (r0 + k < rows) begin
                        w = w | (vals[c*rows + r0 + k] << (7 * (pack - 1 - k)));
                        last = c*rows + r0 + k;
                    end
                end
                exp_addr.push_back(a);
                exp_data.push_back(w);
                exp_idx.push_back(last);
                a++;
            end
        end
    endtask

    task automatic fill_random(input int n);
        vals.delete();
        for (int i = 0; i < n; i++) vals.push_back(int'($urandom_range(1, 127)));
    endtask

    task automatic fill_ramp(input int n);
        vals.delete();
        for (int i = 1; i <= n; i++) vals.push_back(i);
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
    endtask

    // Offers vals[0..n-1]; optional in_valid gaps every third cycle, random start noise, extra junk beats.
    task automatic drive(input int d, input int n, input bit gaps, input bit noise, input int extra);
        int idx = 0;
        int t = 0;
        int budget = 2000;
        int left = extra;
        while ((idx < n || left > 0) && budget > 0) begin
            if (idx < n) begin
                in_valid = !(gaps && (t % 3 == 2));
                in_data  = 7'(vals[idx]);
            end else begin
                in_valid = 1'b1;
                in_data  = 7'h55;
                left--;
            end
            if (noise) start[d] = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (idx < n && in_valid && rdy[d] === 1'b1) idx++;
            @(posedge clk); #1;
            t++;
            budget--;
        end
        in_valid = 1'b0;
        if (noise) start[d] = 1'b0;
        if (budget == 0) timed_out = 1;
    endtask

    task automatic wait_done(input int d);
        int k = 0;
        while (done[d] !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 100) timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({we[i], rdy[i], busy[i], done[i], maddr[i], mdata[i]} !== 68'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: we=%b rdy=%b busy=%b done=%b addr=%0h data=%0h, want all 0",
                         i, we[i], rdy[i], busy[i], done[i], maddr[i], mdata[i]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_default();
        wr_t got[$];
        int  acc[$];
        fill_ramp(32);
        build_model(8, 4, 2, 0);
        wlog.delete(); alog.delete(); timed_out = 0;
        pulse_start(0);
        checks++;
        if (rdy[0] !== 1'b1 || busy[0] !== 1'b1) begin
            errors++; $display("FAIL default_start: in_ready=%b busy=%b, want 1 1", rdy[0], busy[0]);
        end
        drive(0, 32, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({we[0], rdy[0], busy[0], done[0]} !== 4'b1010) begin
            errors++; $display("FAIL default_drain: we,rdy,busy,done=%b, want 1010", {we[0], rdy[0], busy[0], done[0]});
        end
        @(negedge clk);
        checks++;
        if ({we[0], rdy[0], busy[0], done[0]} !== 4'b0001) begin
            errors++; $display("FAIL default_done: we,rdy,busy,done=%b, want 0001", {we[0], rdy[0], busy[0], done[0]});
        end
        foreach (wlog[i]) if (wlog[i].dut == 0) got.push_back(wlog[i]);
        foreach (alog[i]) if (alog[i].dut == 0) acc.push_back(alog[i].cyc);
        checks++;
        if (got.size() !== exp_addr.size()) begin
            errors++; $display("FAIL default_count: got %0d writes, want %0d", got.size(), exp_addr.size());
        end
        foreach (got[j]) if (j < exp_addr.size()) begin
            checks++;
            if (got[j].addr !== exp_addr[j] || got[j].data !== exp_data[j] ||
                got[j].cyc !== ((exp_idx[j] < acc.size()) ? acc[exp_idx[j]] + 1 : -1)) begin
                errors++; $display("FAIL default_word%0d: addr %0d data %0h cyc %0d, want addr %0d data %0h one cycle after its accept",
                                   j, got[j].addr, got[j].data, got[j].cyc, exp_addr[j], exp_data[j]);
            end
        end
        checks++;
        if (got.size() != 16 || got[0].data !== 32'h0082 || got[15].data !== 32'h0FA0) begin
            errors++; $display("FAIL default_ends: %0d writes, first/last data wrong, want 0082 and 0fa0", got.size());
        end
        checks++;
        if (timed_out) begin errors++; $display("FAIL default_timeout: got timeout, want completion"); end
    endtask

    task automatic test_gaps();
        wr_t got[$];
        int  acc[$];
        fill_ramp(32);
        build_model(8, 4, 2, 0);
        wlog.delete(); alog.delete(); timed_out = 0;
        pulse_start(0);
        drive(0, 32, 1, 0, 0);
        wait_done(0);
        foreach (wlog[i]) if (wlog[i].dut == 0) got.push_back(wlog[i]);
        foreach (alog[i]) if (alog[i].dut == 0) acc.push_back(alog[i].cyc);
        checks++;
        if (got.size() !== exp_addr.size() || acc.size() !== 32) begin
            errors++; $display("FAIL gaps_count: %0d writes %0d accepts, want %0d and 32", got.size(), acc.size(), exp_addr.size());
        end
        foreach (got[j]) if (j < exp_addr.size()) begin
            checks++;
            if (got[j].addr !== exp_addr[j] || got[j].data !== exp_data[j] ||
                got[j].cyc !== ((exp_idx[j] < acc.size()) ? acc[exp_idx[j]] + 1 : -1)) begin
                errors++; $display("FAIL gaps_word%0d: addr %0d data %0h cyc %0d, want addr %0d data %0h one cycle after its accept",
                                   j, got[j].addr, got[j].data, got[j].cyc, exp_addr[j], exp_data[j]);
            end
        end
        checks++;
        if (timed_out) begin errors++; $display("FAIL gaps_timeout: got timeout, want completion"); end
    endtask

    task automatic test_reset_midload();
        wr_t got[$];
        int  nwr;
        fill_random(32);
        wlog.delete(); alog.delete(); timed_out = 0;
        pulse_start(0);
        drive(0, 9, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({we[0], rdy[0], busy[0], done[0], maddr[0], mdata[0]} !== 68'd0) begin
            errors++; $display("FAIL midreset_outputs: we=%b rdy=%b busy=%b done=%b addr=%0h data=%0h, want all 0",
                               we[0], rdy[0], busy[0], done[0], maddr[0], mdata[0]);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        nwr = 0;
        foreach (wlog[i]) if (wlog[i].dut == 0) nwr++;
        checks++;
        if (nwr !== 9 / 2 || rdy[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL midreset_idle: %0d writes rdy=%b busy=%b, want %0d writes and idle", nwr, rdy[0], busy[0], 9 / 2);
        end
        fill_ramp(32);
        build_model(8, 4, 2, 0);
        wlog.delete(); alog.delete();
        pulse_start(0);
        drive(0, 32, 0, 0, 0);
        wait_done(0);
        foreach (wlog[i]) if (wlog[i].dut == 0) got.push_back(wlog[i]);
        checks++;
        if (got.size() !== exp_addr.size()) begin
            errors++; $display("FAIL midreset_count: got %0d writes, want %0d", got.size(), exp_addr.size());
        end
        foreach (got[j]) if (j < exp_addr.size()) begin
            checks++;
            if (got[j].addr !== exp_addr[j] || got[j].data !== exp_data[j]) begin
                errors++; $display("FAIL midreset_word%0d: addr %0d data %0h, want addr %0d data %0h",
                                   j, got[j].addr, got[j].data, exp_addr[j], exp_data[j]);
            end
        end
        checks++;
        if (timed_out) begin errors++; $display("FAIL midreset_timeout: got timeout, want completion"); end
    endtask

    task automatic test_restart_base();
        wr_t got[$];
        int  acc[$];
        timed_out = 0;
        fill_random(32);
        pulse_start(1);
        drive(1, 32, 0, 0, 0);
        wait_done(1);
        fill_random(32);
        build_model(8, 4, 2, 8);
        wlog.delete(); alog.delete();
        pulse_start(1);
        checks++;
        if (done[1] !== 1'b0 || rdy[1] !== 1'b1) begin
            errors++; $display("FAIL restart_done_clear: done=%b in_ready=%b, want 0 1", done[1], rdy[1]);
        end
        drive(1, 32, 0, 1, 0);
        wait_done(1);
        foreach (wlog[i]) if (wlog[i].dut == 1) got.push_back(wlog[i]);
        foreach (alog[i]) if (alog[i].dut == 1) acc.push_back(alog[i].cyc);
        checks++;
        if (got.size() !== exp_addr.size() || acc.size() !== 32) begin
            errors++; $display("FAIL restart_count: %0d writes %0d accepts, want %0d and 32", got.size(), acc.size(), exp_addr.size());
        end
        foreach (got[j]) if (j < exp_addr.size()) begin
            checks++;
            if (got[j].addr !== exp_addr[j] || got[j].data !== exp_data[j] ||
                got[j].cyc !== ((exp_idx[j] < acc.size()) ? acc[exp_idx[j]] + 1 : -1)) begin
                errors++; $display("FAIL restart_word%0d: addr %0d data %0h cyc %0d, want addr %0d data %0h one cycle after its accept",
                                   j, got[j].addr, got[j].data, got[j].cyc, exp_addr[j], exp_data[j]);
            end
        end
        checks++;
        if (timed_out) begin errors++; $display("FAIL restart_timeout: got timeout, want completion"); end
    endtask

    task automatic test_partial_words();
        wr_t got[$];
        int  acc[$];
        fill_ramp(10);
        build_model(5, 2, 2, 0);
        wlog.delete(); alog.delete(); timed_out = 0;
        pulse_start(2);
        drive(2, 10, 0, 0, 4);
        wait_done(2);
        foreach (wlog[i]) if (wlog[i].dut == 2) got.push_back(wlog[i]);
        foreach (alog[i]) if (alog[i].dut == 2) acc.push_back(alog[i].cyc);
        checks++;
        if (got.size() !== 6 || acc.size() !== 10) begin
            errors++; $display("FAIL partial_count: %0d writes %0d accepts, want 6 and 10", got.size(), acc.size());
        end
        foreach (got[j]) if (j < exp_addr.size()) begin
            checks++;
            if (got[j].addr !== exp_addr[j] || got[j].data !== exp_data[j] ||
                got[j].cyc !== ((exp_idx[j] < acc.size()) ? acc[exp_idx[j]] + 1 : -1)) begin
                errors++; $display("FAIL partial_word%0d: addr %0d data %0h cyc %0d, want addr %0d data %0h one cycle after its accept",
                                   j, got[j].addr, got[j].data, got[j].cyc, exp_addr[j], exp_data[j]);
            end
        end
        checks++;
        if (got.size() != 6 || got[2].data !== 32'h280 || got[5].data !== 32'h500) begin
            errors++; $display("FAIL partial_padding: padded words wrong, want 280 and 500");
        end
        checks++;
        if (timed_out) begin errors++; $display("FAIL partial_timeout: got timeout, want completion"); end
    endtask

    task automatic test_pack1_start_held();
        wr_t got[$];
        timed_out = 0;
        fill_random(3);
        start[3] = 1'b1;
        @(posedge clk); #1;
        drive(3, 3, 0, 0, 0);
        wait_done(3);
        @(posedge clk); #1;
        checks++;
        if ({done[3], rdy[3], busy[3]} !== 3'b011) begin
            errors++; $display("FAIL pack1_restart: done,rdy,busy=%b, want 011", {done[3], rdy[3], busy[3]});
        end
        fill_random(3);
        build_model(3, 1, 1, 0);
        wlog.delete(); alog.delete();
        drive(3, 3, 0, 0, 0);
        start[3] = 1'b0;
        wait_done(3);
        foreach (wlog[i]) if (wlog[i].dut == 3) got.push_back(wlog[i]);
        checks++;
        if (got.size() !== 3) begin
            errors++; $display("FAIL pack1_count: got %0d writes, want 3", got.size());
        end
        foreach (got[j]) if (j < exp_addr.size()) begin
            checks++;
            if (got[j].addr !== exp_addr[j] || got[j].data !== vals[j]) begin
                errors++; $display("FAIL pack1_word%0d: addr %0d data %0h, want addr %0d data %0h",
                                   j, got[j].addr, got[j].data, exp_addr[j], vals[j]);
            end
        end
        checks++;
        if (timed_out) begin errors++; $display("FAIL pack1_timeout: got timeout, want completion"); end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 4'b0;
        in_valid = 1'b0;
        in_data  = 7'd0;
        test_reset();
        test_default();
        test_gaps();
        test_reset_midload();
        test_restart_base();
        test_partial_words();
        test_pack1_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
